// File: rtl/axil_cfg_sequencer.sv
// Table-driven AXI4-Lite configuration master: walks a ROM of {op, addr, data}
// entries issuing WRITE / POLL / WAIT operations until END, an error or index wrap.
module axil_cfg_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 8,
  parameter int POLL_MAX = 1024
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [IDX_W-1:0]           err_idx,
  output logic [IDX_W-1:0]           tbl_addr,
  input  logic [2+ADDR_W+DATA_W-1:0] tbl_data,
  output logic [ADDR_W-1:0]          m_axi_awaddr,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [DATA_W-1:0]          m_axi_wdata,
  output logic [DATA_W/8-1:0]        m_axi_wstrb,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  output logic [ADDR_W-1:0]          m_axi_araddr,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DATA_W-1:0]          m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam int ENT_W = 2 + ADDR_W + DATA_W;
  localparam int PCW   = $clog2(POLL_MAX + 1);

  localparam logic [1:0] OP_END   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_WAIT  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DELAY, S_FINISH
  } state_t;

  state_t            r_state, w_state_next;
  logic [IDX_W-1:0]  r_idx, w_idx_next;
  logic [IDX_W-1:0]  r_err_idx, w_err_idx_next;
  logic              r_error, w_error_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [DATA_W-1:0] r_data, w_data_next;
  logic              r_awvalid, w_awvalid_next;
  logic              r_wvalid, w_wvalid_next;
  logic [PCW-1:0]    r_poll_cnt, w_poll_cnt_next, w_poll_inc;
  logic [15:0]       r_dly, w_dly_next;
  logic [1:0]        w_op;
  logic              w_advance, w_fail;

  assign w_op       = tbl_data[ENT_W-1 -: 2];
  assign w_poll_inc = r_poll_cnt + PCW'(1);

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_err_idx_next  = r_err_idx;
    w_error_next    = r_error;
    w_addr_next     = r_addr;
    w_data_next     = r_data;
    w_awvalid_next  = r_awvalid;
    w_wvalid_next   = r_wvalid;
    w_poll_cnt_next = r_poll_cnt;
    w_dly_next      = r_dly;
    w_advance       = 1'b0;
    w_fail          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_error_next   = 1'b0;
          w_err_idx_next = '0;
          w_idx_next     = '0;
          w_state_next   = S_FETCH;
        end
      end
      S_FETCH: w_state_next = S_DECODE;
      S_DECODE: begin
        w_addr_next = tbl_data[DATA_W +: ADDR_W];
        w_data_next = tbl_data[DATA_W-1:0];
        case (w_op)
          OP_END:   w_state_next = S_FINISH;
          OP_WRITE: begin
            w_awvalid_next = 1'b1;
            w_wvalid_next  = 1'b1;
            w_state_next   = S_WR;
          end
          OP_POLL: begin
            w_poll_cnt_next = '0;
            w_state_next    = S_RD_ADDR;
          end
          OP_WAIT: begin
            w_dly_next   = tbl_data[15:0];
            w_state_next = S_DELAY;
          end
          default: w_state_next = S_FINISH;
        endcase
      end
      S_WR: begin
        // AW and W complete independently; leave only once neither is still pending.
        if (m_axi_awready) w_awvalid_next = 1'b0;
        if (m_axi_wready)  w_wvalid_next  = 1'b0;
        if ((!r_awvalid || m_axi_awready) && (!r_wvalid || m_axi_wready))
          w_state_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp == 2'b00) w_advance = 1'b1;
          else                      w_fail    = 1'b1;
        end
      end
      S_RD_ADDR: if (m_axi_arready) w_state_next = S_RD_DATA;
      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00)               w_fail = 1'b1;
          else if (m_axi_rdata == r_data)         w_advance = 1'b1;
          else if (w_poll_inc == PCW'(POLL_MAX))  w_fail = 1'b1;
          else begin
            w_poll_cnt_next = w_poll_inc;
            w_state_next    = S_RD_ADDR;
          end
        end
      end
      S_DELAY: begin
        // A count of N occupies N cycles here, with 0 behaving like 1.
        if (r_dly <= 16'd1) w_advance  = 1'b1;
        else                w_dly_next = r_dly - 16'd1;
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase

    if (w_fail) begin
      w_error_next   = 1'b1;
      w_err_idx_next = r_idx;
      w_state_next   = S_FINISH;
    end
    if (w_advance) begin
      if (&r_idx) begin
        w_error_next   = 1'b1;
        w_err_idx_next = '1;
        w_state_next   = S_FINISH;
      end else begin
        w_idx_next   = r_idx + IDX_W'(1);
        w_state_next = S_FETCH;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_err_idx  <= '0;
      r_error    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_poll_cnt <= '0;
      r_dly      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_err_idx  <= w_err_idx_next;
      r_error    <= w_error_next;
      r_addr     <= w_addr_next;
      r_data     <= w_data_next;
      r_awvalid  <= w_awvalid_next;
      r_wvalid   <= w_wvalid_next;
      r_poll_cnt <= w_poll_cnt_next;
      r_dly      <= w_dly_next;
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_FINISH);
  assign error         = r_error;
  assign err_idx       = r_err_idx;
  assign tbl_addr      = r_idx;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_data;
  assign m_axi_wstrb   = {(DATA_W/8){1'b1}};
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = (r_state == S_WR_RESP);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = (r_state == S_RD_ADDR);
  assign m_axi_rready  = (r_state == S_RD_DATA);

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Directed bench for axil_cfg_sequencer: ROM model, reactive AXI-Lite slave on the
// falling edge, and one task per scenario with hand-computed expectations.
module tb_axil_cfg_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int PM = 4;
  localparam int EW = 2 + AW + DW;

  localparam logic [1:0] OP_END  = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_WAIT = 2'b11;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [IW-1:0] err_idx, tbl_addr;
  logic [EW-1:0] tbl_data;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [DW-1:0] m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic          m_axi_awready = 1'b0;
  logic          m_axi_wready  = 1'b0;
  logic [1:0]    m_axi_bresp   = 2'b00;
  logic          m_axi_bvalid  = 1'b0;
  logic          m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata   = '0;
  logic [1:0]    m_axi_rresp   = 2'b00;
  logic          m_axi_rvalid  = 1'b0;

  axil_cfg_sequencer #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(IW), .POLL_MAX(PM)) dut (
    .aclk(aclk), .areset(areset), .start(start),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // Synchronous ROM: data follows the address by one clock.
  logic [EW-1:0] rom [0:255];
  always @(posedge aclk) tbl_data <= rom[tbl_addr];

  int          aw_delay = 0;
  int          w_delay = 0;
  logic [1:0]  bresp_tab [0:7];
  logic [31:0] rdata_tab [0:7];
  bit          clr_req = 1'b0;

  int          aw_cnt = 0, w_cnt = 0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int          aw_hi = 0, w_hi = 0, done_cnt = 0, overlap = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;

  // DUT outputs are pure register decodes, so values seen here hold through the next rising edge.
  always @(negedge aclk) begin
    if (clr_req) begin
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_hi = 0; w_hi = 0; done_cnt = 0;
      last_awaddr = '0; last_wdata = '0; last_araddr = '0; last_wstrb = '0;
    end
    if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= aw_delay); aw_cnt++; end
    else begin m_axi_awready = 1'b0; aw_cnt = 0; end
    if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_delay); w_cnt++; end
    else begin m_axi_wready = 1'b0; w_cnt = 0; end
    m_axi_arready = m_axi_arvalid;
    m_axi_bvalid  = (((aw_hs < w_hs) ? aw_hs : w_hs) > b_hs);
    m_axi_bresp   = bresp_tab[b_hs[2:0]];
    m_axi_rvalid  = (ar_hs > r_hs);
    m_axi_rdata   = rdata_tab[r_hs[2:0]];
    m_axi_rresp   = 2'b00;

    if (m_axi_awvalid && m_axi_awready) begin aw_hs++; last_awaddr = m_axi_awaddr; end
    if (m_axi_wvalid && m_axi_wready) begin
      w_hs++; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
    end
    if (m_axi_bvalid && m_axi_bready) b_hs++;
    if (m_axi_arvalid && m_axi_arready) begin ar_hs++; last_araddr = m_axi_araddr; end
    if (m_axi_rvalid && m_axi_rready) r_hs++;
    if (m_axi_awvalid) aw_hi++;
    if (m_axi_wvalid) w_hi++;
    if (done) done_cnt++;
    if (m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid)) overlap++;
  end

  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] d);
    return {op, a, d};
  endfunction

  task automatic fill_rom(input logic [EW-1:0] e);
    for (int i = 0; i < 256; i++) rom[i] = e;
  endtask

  task automatic set_slave(input int awd, input int wd);
    aw_delay = awd;
    w_delay  = wd;
    for (int i = 0; i < 8; i++) begin bresp_tab[i] = 2'b00; rdata_tab[i] = 32'h0; end
  endtask

  task automatic clear_slave();
    clr_req = 1'b1;
    @(negedge aclk);
    #1 clr_req = 1'b0;
  endtask

  task automatic run_seq(input string name, output int cyc);
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(posedge aclk); #1;
      cyc++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required done=1", name, done, cyc);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    n_cmp++;
    if ({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
    end
    n_cmp++;
    if ({err_idx, tbl_addr} !== 16'h0) begin
      n_fail++; $display("FAIL reset_idx: err_idx=%0d tbl_addr=%0d required 0/0", err_idx, tbl_addr);
    end
    areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    $display("test_reset: busy=%b error=%b tbl_addr=%0d", busy, error, tbl_addr);
  endtask

  task automatic test_write();
    int cyc;
    fill_rom(ent(OP_END, 0, 0));
    rom[0] = ent(OP_WR, 32'h0000_0010, 32'hDEAD_BEEF);
    set_slave(0, 0);
    clear_slave();
    run_seq("write", cyc);
    n_cmp++; if (cyc !== 6) begin n_fail++; $display("FAIL write_latency: got %0d required 6", cyc); end
    n_cmp++; if (aw_hs !== 1 || w_hs !== 1) begin
      n_fail++; $display("FAIL write_hs: aw=%0d w=%0d required 1/1", aw_hs, w_hs); end
    n_cmp++; if (last_awaddr !== 32'h10) begin
      n_fail++; $display("FAIL write_awaddr: got %h required 00000010", last_awaddr); end
    n_cmp++; if (last_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_wdata: got %h required deadbeef", last_wdata); end
    n_cmp++; if (last_wstrb !== 4'hF) begin
      n_fail++; $display("FAIL write_wstrb: got %h required f", last_wstrb); end
    n_cmp++; if (b_hs !== 1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL write_b_done: b=%0d done=%0d required 1/1", b_hs, done_cnt); end
    n_cmp++; if (error !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL write_end_state: error=%b busy=%b required 0/0", error, busy); end
    $display("test_write: cycles=%0d awaddr=%h wdata=%h", cyc, last_awaddr, last_wdata);
  endtask

  task automatic test_aw_stall();
    int cyc;
    set_slave(5, 0);
    clear_slave();
    run_seq("aw_stall", cyc);
    n_cmp++; if (aw_hi !== 6) begin n_fail++; $display("FAIL stall_awvalid_cycles: got %0d required 6", aw_hi); end
    n_cmp++; if (w_hi !== 1) begin n_fail++; $display("FAIL stall_wvalid_cycles: got %0d required 1", w_hi); end
    n_cmp++; if (b_hs !== 1 || aw_hs !== 1) begin
      n_fail++; $display("FAIL stall_hs: b=%0d aw=%0d required 1/1", b_hs, aw_hs); end
    n_cmp++; if (cyc !== 11) begin n_fail++; $display("FAIL stall_latency: got %0d required 11", cyc); end
    $display("test_aw_stall: cycles=%0d awvalid_hi=%0d wvalid_hi=%0d", cyc, aw_hi, w_hi);
  endtask

  task automatic test_poll();
    int cyc;
    fill_rom(ent(OP_END, 0, 0));
    rom[0] = ent(OP_POLL, 32'h0000_0020, 32'h1);
    set_slave(0, 0);
    rdata_tab[3] = 32'h1;
    clear_slave();
    run_seq("poll", cyc);
    n_cmp++; if (ar_hs !== 4 || r_hs !== 4) begin
      n_fail++; $display("FAIL poll_reads: ar=%0d r=%0d required 4/4", ar_hs, r_hs); end
    n_cmp++; if (last_araddr !== 32'h20) begin
      n_fail++; $display("FAIL poll_araddr: got %h required 00000020", last_araddr); end
    n_cmp++; if (error !== 1'b0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL poll_status: error=%b done=%0d required 0/1", error, done_cnt); end
    n_cmp++; if (cyc !== 12) begin n_fail++; $display("FAIL poll_latency: got %0d required 12", cyc); end
    n_cmp++; if (aw_hs !== 0) begin n_fail++; $display("FAIL poll_no_write: aw=%0d required 0", aw_hs); end
    $display("test_poll: cycles=%0d reads=%0d", cyc, ar_hs);
  endtask

  task automatic test_poll_timeout();
    int cyc;
    set_slave(0, 0);
    clear_slave();
    run_seq("poll_to", cyc);
    n_cmp++; if (ar_hs !== PM) begin n_fail++; $display("FAIL pollto_reads: got %0d required %0d", ar_hs, PM); end
    n_cmp++; if (error !== 1'b1 || err_idx !== 8'd0) begin
      n_fail++; $display("FAIL pollto_err: error=%b err_idx=%0d required 1/0", error, err_idx); end
    n_cmp++; if (done_cnt !== 1 || cyc !== 10) begin
      n_fail++; $display("FAIL pollto_done: done=%0d cycles=%0d required 1/10", done_cnt, cyc); end
    $display("test_poll_timeout: cycles=%0d reads=%0d err_idx=%0d", cyc, ar_hs, err_idx);
  endtask

  task automatic test_bresp_err();
    int cyc;
    fill_rom(ent(OP_END, 0, 0));
    rom[0] = ent(OP_WR, 32'h100, 32'h1);
    rom[1] = ent(OP_WR, 32'h104, 32'h2);
    rom[2] = ent(OP_WR, 32'h108, 32'h3);
    set_slave(0, 0);
    bresp_tab[1] = 2'b10;
    clear_slave();
    run_seq("bresp", cyc);
    n_cmp++; if (aw_hs !== 2 || w_hs !== 2) begin
      n_fail++; $display("FAIL bresp_writes: aw=%0d w=%0d required 2/2", aw_hs, w_hs); end
    n_cmp++; if (last_awaddr !== 32'h104) begin
      n_fail++; $display("FAIL bresp_last_addr: got %h required 00000104", last_awaddr); end
    n_cmp++; if (error !== 1'b1 || err_idx !== 8'd1) begin
      n_fail++; $display("FAIL bresp_err: error=%b err_idx=%0d required 1/1", error, err_idx); end
    n_cmp++; if (cyc !== 8) begin n_fail++; $display("FAIL bresp_latency: got %0d required 8", cyc); end
    repeat (3) @(posedge aclk);
    #1;
    n_cmp++; if (error !== 1'b1 || aw_hs !== 2) begin
      n_fail++; $display("FAIL bresp_sticky: error=%b aw=%0d required 1/2", error, aw_hs); end
    $display("test_bresp_err: cycles=%0d writes=%0d err_idx=%0d", cyc, aw_hs, err_idx);
  endtask

  task automatic test_wait();
    int cyc;
    fill_rom(ent(OP_END, 0, 0));
    rom[0] = ent(OP_WAIT, 32'h0, 32'h3);
    set_slave(0, 0);
    clear_slave();
    run_seq("wait3", cyc);
    n_cmp++; if (cyc !== 7) begin n_fail++; $display("FAIL wait3_latency: got %0d required 7", cyc); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL wait3_error_cleared: got %b required 0", error); end
    $display("test_wait: WAIT 3 cycles=%0d", cyc);
    rom[0] = ent(OP_WAIT, 32'h0, 32'h0);
    run_seq("wait0", cyc);
    n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL wait0_latency: got %0d required 5", cyc); end
    $display("test_wait: WAIT 0 cycles=%0d", cyc);
  endtask

  task automatic test_start_ignored();
    int cyc;
    fill_rom(ent(OP_END, 0, 0));
    rom[0] = ent(OP_WAIT, 32'h0, 32'd20);
    clear_slave();
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      start = (cyc == 5);
      @(posedge aclk); #1;
      cyc++;
    end
    start = 1'b0;
    n_cmp++; if (cyc !== 24) begin n_fail++; $display("FAIL busy_start_latency: got %0d required 24", cyc); end
    repeat (3) @(posedge aclk);
    #1;
    n_cmp++; if (done_cnt !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_rerun: done=%0d busy=%b required 1/0", done_cnt, busy); end
    $display("test_start_ignored: cycles=%0d done_pulses=%0d", cyc, done_cnt);
  endtask

  task automatic test_idx_wrap();
    int cyc;
    fill_rom(ent(OP_WAIT, 32'h0, 32'h0));
    clear_slave();
    run_seq("wrap", cyc);
    n_cmp++; if (error !== 1'b1 || err_idx !== 8'd255) begin
      n_fail++; $display("FAIL wrap_err: error=%b err_idx=%0d required 1/255", error, err_idx); end
    n_cmp++; if (cyc !== 768) begin n_fail++; $display("FAIL wrap_latency: got %0d required 768", cyc); end
    $display("test_idx_wrap: cycles=%0d err_idx=%0d", cyc, err_idx);
  endtask

  task automatic test_reset_mid();
    int cyc;
    fill_rom(ent(OP_END, 0, 0));
    rom[0] = ent(OP_WR, 32'h40, 32'h55);
    set_slave(5, 0);
    clear_slave();
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    cyc = 0;
    while (m_axi_awvalid !== 1'b1 && cyc < 20) begin @(posedge aclk); #1; cyc++; end
    n_cmp++; if (m_axi_awvalid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_awvalid_seen: got %b required 1", m_axi_awvalid); end
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy} !== 4'b0) begin
      n_fail++; $display("FAIL rstmid_drop: aw/w/b/busy=%b required 0000",
                         {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy}); end
    n_cmp++; if (tbl_addr !== 8'd0) begin n_fail++; $display("FAIL rstmid_idx: got %0d required 0", tbl_addr); end
    areset = 1'b0;
    @(posedge aclk); #1;
    set_slave(0, 0);
    clear_slave();
    run_seq("rstmid_rerun", cyc);
    n_cmp++; if (aw_hs !== 1 || last_awaddr !== 32'h40 || b_hs !== 1) begin
      n_fail++; $display("FAIL rstmid_rerun: aw=%0d awaddr=%h b=%0d required 1/00000040/1", aw_hs, last_awaddr, b_hs); end
    n_cmp++; if (cyc !== 6 || error !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_rerun_status: cycles=%0d error=%b required 6/0", cyc, error); end
    $display("test_reset_mid: rerun cycles=%0d awaddr=%h", cyc, last_awaddr);
  endtask

  initial begin
    fill_rom(ent(OP_END, 0, 0));
    set_slave(0, 0);
    test_reset();
    test_write();
    test_aw_stall();
    test_poll();
    test_poll_timeout();
    test_bresp_err();
    test_wait();
    test_start_ignored();
    test_idx_wrap();
    test_reset_mid();
    n_cmp++;
    if (overlap !== 0) begin n_fail++; $display("FAIL aw_ar_overlap: got %0d cycles required 0", overlap); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
